// File: rtl/div_seq_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// Handshake: a request is taken when start=1, op!=0 and flush=0 in IDLE; busy covers CALC and DONE; valid_out pulses once in DONE.
module div_seq_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            valid_out,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_q, result_q;
    logic [4:0]       rd_q, rd_out_q;
    logic             is_rem_q, neg_a_q, neg_b_q;

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    // Request decode; lower op bits take priority when several are set.
    logic            in_signed, in_rem, sign_a, sign_b;
    logic            div_zero, ovf, special, accept, last;
    logic [XLEN-1:0] abs_a, abs_b, spec_result;

    assign in_signed   = op[0] | (~op[1] & op[2]);
    assign in_rem      = ~op[0] & ~op[1];
    assign sign_a      = in_signed & rs1_val[XLEN-1];
    assign sign_b      = in_signed & rs2_val[XLEN-1];
    assign abs_a       = sign_a ? neg(rs1_val) : rs1_val;
    assign abs_b       = sign_b ? neg(rs2_val) : rs2_val;
    assign div_zero    = (rs2_val == '0);
    assign ovf         = in_signed && (rs1_val == MIN_NEG) && (rs2_val == '1);
    assign special     = div_zero | ovf;
    assign spec_result = div_zero ? (in_rem ? rs1_val : '1) : (in_rem ? '0 : MIN_NEG);
    assign accept      = (state_q == IDLE) && start && (op != 4'd0) && !flush;
    assign last        = (state_q == CALC) && (cnt_q == CNT_W'(XLEN-1));

    // One restoring step; sub[XLEN] is the borrow of the XLEN+1 bit trial subtract.
    logic [XLEN:0]   rem_sh, sub;
    logic            borrow;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix, fin;

    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign sub    = rem_sh - {1'b0, dvs_q};
    assign borrow = sub[XLEN];
    assign rem_nx = borrow ? rem_sh[XLEN-1:0] : sub[XLEN-1:0];
    assign quo_nx = {quo_q[XLEN-2:0], ~borrow};
    assign q_fix  = (neg_a_q ^ neg_b_q) ? neg(quo_nx) : quo_nx;
    assign r_fix  = neg_a_q ? neg(rem_nx) : rem_nx;
    assign fin    = is_rem_q ? r_fix : q_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: begin
                if (flush)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        valid_out = (state_q == DONE) && !flush;
    end

    // Result and rd_out are written on entry to DONE and then held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            is_rem_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= abs_a;
            dvs_q    <= abs_b;
            rd_q     <= rd_in;
            is_rem_q <= in_rem;
            neg_a_q  <= sign_a;
            neg_b_q  <= sign_b;
            if (special) begin
                result_q <= spec_result;
                rd_out_q <= rd_in;
            end
        end else if (state_q == CALC && !flush) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                result_q <= fin;
                rd_out_q <= rd_q;
            end
        end
    end

    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Bench for div_seq_unit: directed cases, special cases, flush, busy/start
// interaction, async reset and randomized back-to-back ops against a reference model.
module tb_div_seq_unit;

    localparam int TIMEOUT = 80;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy, valid_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    div_seq_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy), .valid_out(valid_out), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (o[0]) begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
        end else if (o[1]) begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
        end else if (o[2]) begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return sa % sb;
        end else begin
            if (b == 0) return a;
            return a % b;
        end
    endfunction

    function automatic int ref_latency(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = o[0] | (~o[1] & o[2]);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Driver: start edge is cycle 0; returns the first valid_out cycle (or -1).
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int bcnt);
        int cyc;
        lat = -1; bcnt = 0; res = '0; rdo = '0;
        @(negedge clk);
        start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = r;
        @(negedge clk);
        start = 1'b0; op = 4'd0; rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom);
        cyc = 1;
        while (lat < 0 && cyc <= TIMEOUT) begin
            if (busy) bcnt++;
            if (valid_out) begin
                lat = cyc; res = result; rdo = rd_out;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 4'd0; rs1_val = '0; rs2_val = '0; rd_in = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (rd_out !== 5'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", rd_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [3:0]  t_op[9]  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0100, 4'b0010, 4'b1000, 4'b0011, 4'b1100};
        logic [31:0] t_a[9]   = '{32'd20, 32'd20, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 32'hFFFF_FFEC};
        logic [31:0] t_b[9]   = '{32'd3, 32'd3, 32'd3, 32'd3, 32'hFFFF_FFFD, 32'd2, 32'd2, 32'd3, 32'd3};
        logic [31:0] t_exp[9] = '{32'd6, 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFA, 32'hFFFF_FFFE};
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bcnt;
        for (int i = 0; i < 9; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 5'(i + 1), res, rdo, lat, bcnt);
            checks++; if (res !== t_exp[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, res, t_exp[i]); end
            checks++; if (lat != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); end
            checks++; if (bcnt != 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, bcnt); end
            checks++; if (rdo !== 5'(i + 1)) begin errors++; $display("FAIL dir%0d_rd: got %0d expected %0d", i, rdo, i + 1); end
        end
        repeat (3) @(negedge clk);
        checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL hold_result: got %h expected fffffffe", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_special;
        logic [3:0]  t_op[4]  = '{4'b0001, 4'b1000, 4'b0001, 4'b0100};
        logic [31:0] t_a[4]   = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b[4]   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp[4] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 5'(20 + i), res, rdo, lat, bcnt);
            checks++; if (res !== t_exp[i]) begin errors++; $display("FAIL spec%0d_result: got %h expected %h", i, res, t_exp[i]); end
            checks++; if (lat != 1) begin errors++; $display("FAIL spec%0d_latency: got %0d expected 1", i, lat); end
            checks++; if (rdo !== 5'(20 + i)) begin errors++; $display("FAIL spec%0d_rd: got %0d expected %0d", i, rdo, 20 + i); end
        end
    endtask

    task automatic test_flush;
        int cyc, lat, seen;
        @(negedge clk);
        start = 1'b1; op = 4'b0001; rs1_val = 32'd20; rs2_val = 32'd3; rd_in = 5'd11;
        @(negedge clk);
        start = 1'b0; cyc = 1; seen = 0;
        while (cyc < 10) begin
            if (valid_out) seen++;
            @(negedge clk); cyc++;
        end
        flush = 1'b1;
        @(negedge clk); cyc++;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        if (valid_out) seen++;
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_valid: got %0d strobes expected 0", seen); end
        start = 1'b1; op = 4'b0001; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd12;
        @(negedge clk); cyc++;
        start = 1'b0; lat = -1;
        while (lat < 0 && cyc <= TIMEOUT) begin
            if (valid_out) lat = cyc;
            else begin @(negedge clk); cyc++; end
        end
        checks++; if (lat != 44) begin errors++; $display("FAIL flush_restart_cycle: got %0d expected 44", lat); end
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_restart_result: got %0d expected 14", result); end
        checks++; if (rd_out !== 5'd12) begin errors++; $display("FAIL flush_restart_rd: got %0d expected 12", rd_out); end
    endtask

    task automatic test_start_while_busy;
        int cyc, lat;
        @(negedge clk);
        start = 1'b1; op = 4'b0001; rs1_val = 32'd20; rs2_val = 32'd3; rd_in = 5'd9;
        @(negedge clk);
        cyc = 1; lat = -1;
        while (lat < 0 && cyc <= TIMEOUT) begin
            if (cyc == 5 || cyc == 20) begin
                start = 1'b1; op = 4'b0010; rs1_val = 32'd1000; rs2_val = 32'd10; rd_in = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (valid_out) lat = cyc;
            else begin @(negedge clk); cyc++; end
        end
        start = 1'b0;
        checks++; if (lat != 33) begin errors++; $display("FAIL busy_start_latency: got %0d expected 33", lat); end
        checks++; if (result !== 32'd6) begin errors++; $display("FAIL busy_start_result: got %0d expected 6", result); end
        checks++; if (rd_out !== 5'd9) begin errors++; $display("FAIL busy_start_rd: got %0d expected 9", rd_out); end
    endtask

    task automatic test_random_back_to_back;
        logic [3:0]  o;
        logic [31:0] a, b, res, exp_r;
        logic [4:0]  r, rdo;
        int lat, bcnt, exp_l, kind;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(1, 15));
            a = $urandom;
            kind = $urandom_range(0, 9);
            case (kind)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 16);
                3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                default: b = $urandom;
            endcase
            r = 5'($urandom);
            exp_r = ref_model(o, a, b);
            exp_l = ref_latency(o, a, b);
            issue(o, a, b, r, res, rdo, lat, bcnt);
            checks++; if (res !== exp_r) begin errors++; $display("FAIL rnd%0d_result: op=%b a=%h b=%h got %h expected %h", i, o, a, b, res, exp_r); end
            checks++; if (lat != exp_l) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, exp_l); end
            checks++; if (rdo !== r) begin errors++; $display("FAIL rnd%0d_rd: got %0d expected %0d", i, rdo, r); end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        start = 1'b1; op = 4'b0001; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", valid_out); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL async_rst_result: got %h expected 0", result); end
        checks++; if (rd_out !== 5'h0) begin errors++; $display("FAIL async_rst_rd: got %h expected 0", rd_out); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_flush();
        test_start_while_busy();
        test_random_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq_unit.md
Name: div_seq_unit

Overview:
- Multi-cycle sequencer for the M-extension divide/remainder ops (DIV, DIVU, REM, REMU).
- Sits in the execute stage beside the ALU. Takes the decoded one-hot op and operand values, runs an iterative restoring divider, and returns the result with rd.
- Holds busy so the pipeline control can stall fetch/decode while the divide is in progress.

Parameters:
- XLEN, 32: operand and result width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  4  one-hot op: [0]=DIV, [1]=DIVU, [2]=REM, [3]=REMU (decoder signals 41..44).
- rs1_val  input  XLEN  dividend.
- rs2_val  input  XLEN  divisor.
- rd_in  input  5  destination register index.
- flush  input  1  abort the in-flight op (branch/trap).
- busy  output  1  high in CALC and DONE.
- valid_out  output  1  one-cycle result strobe.
- result  output  XLEN  quotient or remainder.
- rd_out  output  5  latched rd.

Behaviour:
Reset (asynchronous, active-high): state=IDLE, busy=0, valid_out=0, result=0, rd_out=0, counter=0, all internal registers 0.

States: IDLE, CALC, DONE.

IDLE:
- Condition for acceptance: start=1, op!=0 and flush=0.
- If op has more than one bit set, priority is DIV > DIVU > REM > REMU.
- On acceptance, latch op, rd_in and the operand signs.
- For DIV/REM, latch |rs1_val| and |rs2_val|. For DIVU/REMU, latch the raw values.
- Clear the partial remainder and set counter=0.
- Special cases go directly to DONE with the result precomputed:
  - Divisor zero: quotient = all ones; remainder = rs1_val unchanged.
  - Signed overflow (DIV/REM, rs1 = 0x80000000, rs2 = 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- All other accepted requests go to CALC.
- start with op=0 is ignored.

CALC, one iteration per cycle:
- Shift {rem, quo} left by 1, bringing the dividend MSB into rem.
- Trial-subtract the divisor using an XLEN+1 bit subtractor.
- If no borrow, keep the difference and set quo LSB=1; otherwise restore and set quo LSB=0.
- Increment counter. After iteration XLEN-1 (counter==XLEN-1), go to DONE.

DONE (one cycle):
- valid_out=1.
- For signed ops, apply sign fix-up:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- result = quotient for DIV/DIVU, remainder for REM/REMU.
- Next state is IDLE. start is not accepted in DONE.
- result and rd_out hold their values after DONE until the next DONE or reset.

Latency, counting the start edge as cycle 0:
- Normal op: valid_out high in cycle XLEN+1 (33).
- Special case: valid_out high in cycle 1.
- Back-to-back ops: the next start is accepted in the cycle after DONE.

flush:
- In CALC or DONE: next state is IDLE, and valid_out is forced 0 that cycle and for the aborted op.
- In IDLE together with start: flush wins and the request is dropped.

start while busy: ignored; latched operands are unaffected.

Widths: all arithmetic is modulo 2^XLEN. The negation of 0x80000000 stays 0x80000000; this is correct for the unsigned magnitude path.

Test Plan:
- DIV 20/3 -> valid_out in cycle 33, result=6, rd_out=rd_in; repeat as REM -> result=2.
- DIV -20/3 -> 0xFFFFFFFA (-6); REM -20/3 -> 0xFFFFFFFE (-2); REM 20/-3 -> 2.
- DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU 0xFFFFFFFF/2 -> 1; busy high in cycles 1..33.
- Divide by zero:
  - DIV 7/0 -> 0xFFFFFFFF in cycle 1.
  - REMU 7/0 -> 7 in cycle 1.
  - Signed overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- flush in cycle 10 of a DIV -> busy low in cycle 11 and no valid_out. A new start in cycle 11 completes correctly (100/7=14 in cycle 44).
- start pulsed with different operands in cycles 5 and 20 of an active DIV 20/3 -> ignored, result still 6. Asynchronous rst mid-CALC -> all outputs 0 immediately.
